// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;
    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr} entries with push/pop/flush; flush wins over same-cycle push/pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fetch_entry_t     wdata_i,
    output fetch_entry_t     head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_push  = push_i && !flush_i;
        do_pop   = pop_i && !flush_i && (count_q != '0);
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

    // Issue credit upstream must make a push into a full, non-draining queue impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !flush_i && full_o && !do_pop));
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: sequential issue with bounded outstanding requests, prefetch queue, redirect.
// Optional FETCH_BYPASS_EN: forward a live response straight to decode when the queue is empty.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            instr_read,
    output logic [XLEN-1:0] instr_addr,
    input  logic            instr_valid,
    input  logic [XLEN-1:0] instr_out,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_pc,
    output logic [XLEN-1:0] fetch_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = ((OW > CW) ? OW : CW) + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [XLEN-1:0] redir_pc;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic [OW-1:0]   drop_cnt_q, drop_cnt_d;
    fetch_entry_t    hold_q, hold_d;
    fetch_entry_t    q_head, fetch_ent;
    logic [CW-1:0]   q_count;
    logic            q_empty, q_full, q_push, q_pop;
    logic            resp_live, bypass, issue;
    logic [SW-1:0]   credit;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .flush_i (redirect_valid),
        .wdata_i ({resp_pc_q, instr_out}),
        .head_o  (q_head),
        .empty_o (q_empty),
        .full_o  (q_full),
        .count_o (q_count)
    );

    // Credit counts queued entries plus live (non-dropped) requests still in flight.
    always_comb begin
        credit = SW'(q_count) + SW'(outstanding_q) - SW'(drop_cnt_q);
        issue  = !rst && !redirect_valid && !q_full
              && (outstanding_q < OW'(MAX_OUTSTANDING))
              && (credit < SW'(DEPTH));
    end

    assign instr_read = issue;
    assign instr_addr = pc_q;

    // Redirect drops every request that is still unanswered after this edge.
    always_comb begin
        redir_pc      = redirect_pc & ~XLEN'(INSTR_BYTES - 1);
        resp_live     = instr_valid && (drop_cnt_q == '0);
        outstanding_d = outstanding_q + OW'(issue) - OW'(instr_valid);
        drop_cnt_d    = drop_cnt_q;
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        if (redirect_valid) begin
            drop_cnt_d = outstanding_d;
            pc_d       = redir_pc;
            resp_pc_d  = redir_pc;
        end else begin
            if (instr_valid && !resp_live) begin
                drop_cnt_d = drop_cnt_q - OW'(1);
            end
            if (issue) begin
                pc_d = pc_q + XLEN'(INSTR_BYTES);
            end
            if (resp_live) begin
                resp_pc_d = resp_pc_q + XLEN'(INSTR_BYTES);
            end
        end
    end

    always_comb begin
`ifdef FETCH_BYPASS_EN
        bypass = resp_live && q_empty && !redirect_valid;
`else
        bypass = 1'b0;
`endif
        fetch_valid = bypass || !q_empty;
        if (bypass) begin
            fetch_ent = {resp_pc_q, instr_out};
        end else if (!q_empty) begin
            fetch_ent = q_head;
        end else begin
            fetch_ent = hold_q;
        end
        hold_d = fetch_valid ? fetch_ent : hold_q;
        q_pop  = !q_empty && fetch_ready;
        q_push = resp_live && !(bypass && fetch_ready);
    end

    assign fetch_pc    = fetch_ent.pc;
    assign fetch_instr = fetch_ent.instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            hold_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            hold_q        <= hold_d;
        end
    end
endmodule
